// File: rtl/csa_pkg.sv
// Shared sizing helpers for the carry-save multi-operand adder.
// Vector counts per level drive the generate structure of csa_tree_adder.
package csa_pkg;

  localparam int MAX_OPS    = 9;
  localparam int MAX_LEVELS = 4;

  function automatic int csa_levels(input int n);
    if (n <= 3)      return 1;
    else if (n == 4) return 2;
    else if (n <= 6) return 3;
    else             return 4;
  endfunction

  function automatic int csa_out_w(input int width, input int n);
    return width + $clog2(n);
  endfunction

  // Live vectors after lvl levels: each group of three becomes two, leftovers pass.
  function automatic int csa_count(input int n, input int unsigned lvl);
    int c;
    c = n;
    for (int unsigned i = 0; i < lvl; i++) c = 2 * (c / 3) + (c % 3);
    return c;
  endfunction

  // Start index (in vectors) of level lvl within the flattened level bus.
  function automatic int csa_offset(input int n, input int unsigned lvl);
    int o;
    o = 0;
    for (int unsigned i = 0; i < lvl; i++) o = o + csa_count(n, i);
    return o;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 full-adder cells: sum vector plus carry vector shifted left by one.
module csa_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  logic [WIDTH-2:0] maj;

  // The MSB carry falls off the modular result, so it is never formed.
  always_comb begin
    sum_o   = a_i ^ b_i ^ c_i;
    maj     = (a_i[WIDTH-2:0] & b_i[WIDTH-2:0]) |
              (a_i[WIDTH-2:0] & c_i[WIDTH-2:0]) |
              (b_i[WIDTH-2:0] & c_i[WIDTH-2:0]);
    carry_o = {maj, 1'b0};
  end

endmodule

// File: rtl/csa_tree_adder.sv
// Pipelined carry-save multi-operand adder with valid/ready backpressure.
// One register stage per compressor level plus one after the final add.
module csa_tree_adder
  import csa_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4,
  parameter int SIGNED  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_OPS*WIDTH-1:0]               in_ops,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [csa_out_w(WIDTH, NUM_OPS)-1:0]   out_sum,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int OUT_W = csa_out_w(WIDTH, NUM_OPS);
  localparam int L     = csa_levels(NUM_OPS);
  localparam int OF    = csa_offset(NUM_OPS, L);
  localparam int TOT   = OF + 2;

  // All levels packed back to back; level l occupies csa_count(l) vectors.
  logic [TOT*OUT_W-1:0] bus;
  logic [L:0]           vld_q;
  logic [OUT_W-1:0]     sum_q;
  logic                 stall;

  assign stall     = vld_q[L] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[L];
  assign out_sum   = sum_q;

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_ext
    logic [WIDTH-1:0] op;
    assign op = in_ops[gi*WIDTH +: WIDTH];
    assign bus[gi*OUT_W +: OUT_W] = (SIGNED != 0) ? {{(OUT_W-WIDTH){op[WIDTH-1]}}, op}
                                                  : {{(OUT_W-WIDTH){1'b0}}, op};
  end

  for (genvar gl = 0; gl < L; gl++) begin : g_lvl
    localparam int NI = csa_count(NUM_OPS, gl);
    localparam int NO = csa_count(NUM_OPS, gl + 1);
    localparam int NG = NI / 3;
    localparam int OI = csa_offset(NUM_OPS, gl);
    localparam int OO = csa_offset(NUM_OPS, gl + 1);

    logic [NI-1:0][OUT_W-1:0] cur;
    logic [NO-1:0][OUT_W-1:0] nxt_d;
    logic [NO-1:0][OUT_W-1:0] vec_q;

    assign cur = bus[OI*OUT_W +: NI*OUT_W];

    for (genvar gg = 0; gg < NG; gg++) begin : g_row
      csa_row #(.WIDTH(OUT_W)) u_row (
        .a_i     (cur[3*gg]),
        .b_i     (cur[3*gg+1]),
        .c_i     (cur[3*gg+2]),
        .sum_o   (nxt_d[2*gg]),
        .carry_o (nxt_d[2*gg+1])
      );
    end

    for (genvar gp = 0; gp < NI - 3*NG; gp++) begin : g_pass
      assign nxt_d[2*NG+gp] = cur[3*NG+gp];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      vec_q <= '0;
      else if (!stall) vec_q <= nxt_d;
    end

    assign bus[OO*OUT_W +: NO*OUT_W] = vec_q;
  end

  // Unstalled means in_ready is high, so in_valid alone marks a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum_q <= '0;
    end else if (!stall) begin
      vld_q <= {vld_q[L-1:0], in_valid};
      sum_q <= bus[OF*OUT_W +: OUT_W] + bus[(OF+1)*OUT_W +: OUT_W];
    end
  end

endmodule

// File: tb/tb_csa_tree_adder.sv
// Directed bench for csa_tree_adder: unsigned/signed 4-operand and 9-operand builds.
module tb_csa_tree_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] ops0; logic iv0, ir0, ov0, ordy0; logic [9:0] sum0;
  logic [31:0] ops1; logic iv1, ir1, ov1, ordy1; logic [9:0] sum1;
  logic [35:0] ops2; logic iv2, ir2, ov2, ordy2; logic [7:0] sum2;

  csa_tree_adder #(.WIDTH(8), .NUM_OPS(4), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_ops(ops0), .in_valid(iv0), .in_ready(ir0),
    .out_sum(sum0), .out_valid(ov0), .out_ready(ordy0));

  csa_tree_adder #(.WIDTH(8), .NUM_OPS(4), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_ops(ops1), .in_valid(iv1), .in_ready(ir1),
    .out_sum(sum1), .out_valid(ov1), .out_ready(ordy1));

  csa_tree_adder #(.WIDTH(4), .NUM_OPS(9), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_ops(ops2), .in_valid(iv2), .in_ready(ir2),
    .out_sum(sum2), .out_valid(ov2), .out_ready(ordy2));

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({ov0, ov1, ov2} !== 3'b000) begin errors++;
      $display("FAIL reset_out_valid: got %b want 000", {ov0, ov1, ov2}); end
    checks++; if (sum0 !== 10'h000) begin errors++; $display("FAIL reset_sum0: got %h want 000", sum0); end
    checks++; if (sum1 !== 10'h000) begin errors++; $display("FAIL reset_sum1: got %h want 000", sum1); end
    checks++; if (sum2 !== 8'h00) begin errors++; $display("FAIL reset_sum2: got %h want 00", sum2); end
    rst_n = 1'b1;
    #1;
    checks++; if ({ir0, ir1, ir2} !== 3'b111) begin errors++;
      $display("FAIL reset_in_ready: got %b want 111", {ir0, ir1, ir2}); end
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [31:0] tops [2] = '{{4{8'hFF}}, 32'h0};
    logic [9:0]  texp [2] = '{10'h3FC, 10'h000};
    for (int t = 0; t < 2; t++) begin
      ops0 = tops[t]; iv0 = 1'b1; ordy0 = 1'b1;
      @(negedge clk);
      iv0 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++; if (ov0 !== (c == 3)) begin errors++;
          $display("FAIL unsigned_latency[%0d] cycle %0d: got out_valid=%b want %b", t, c, ov0, (c == 3)); end
        if (c < 3) @(negedge clk);
      end
      checks++; if (sum0 !== texp[t]) begin errors++;
        $display("FAIL unsigned_sum[%0d]: got %h want %h", t, sum0, texp[t]); end
      @(negedge clk);
    end
  endtask

  task automatic test_signed();
    logic [31:0] tops [2] = '{{4{8'h80}}, {8'hFF, 8'h01, 8'h80, 8'h7F}};
    logic [9:0]  texp [2] = '{10'h200, 10'h3FF};
    for (int t = 0; t < 2; t++) begin
      ops1 = tops[t]; iv1 = 1'b1; ordy1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++; if (ov1 !== (c == 3)) begin errors++;
          $display("FAIL signed_latency[%0d] cycle %0d: got out_valid=%b want %b", t, c, ov1, (c == 3)); end
        if (c < 3) @(negedge clk);
      end
      checks++; if (sum1 !== texp[t]) begin errors++;
        $display("FAIL signed_sum[%0d]: got %h want %h", t, sum1, texp[t]); end
      @(negedge clk);
    end
  endtask

  task automatic test_nine_ops();
    ops2 = {9{4'hF}}; iv2 = 1'b1; ordy2 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++; if (ov2 !== (c == 5)) begin errors++;
        $display("FAIL nine_latency cycle %0d: got out_valid=%b want %b", c, ov2, (c == 5)); end
      if (c < 5) @(negedge clk);
    end
    checks++; if (sum2 !== 8'h87) begin errors++; $display("FAIL nine_sum: got %h want 87", sum2); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0]  exp_q [$];
    logic [31:0] r;
    int got = 0, first = -1, last = -1, sent = 0;
    ordy0 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ov0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++;
          $display("FAIL b2b_extra: got %h want no result", sum0); end
        else begin
          if (sum0 !== exp_q[0]) begin errors++;
            $display("FAIL b2b_sum[%0d]: got %h want %h", got, sum0, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (sent < 50) begin
        r = $urandom;
        ops0 = r; iv0 = 1'b1;
        exp_q.push_back(10'(r[7:0]) + 10'(r[15:8]) + 10'(r[23:16]) + 10'(r[31:24]));
        sent++;
      end else iv0 = 1'b0;
      @(negedge clk);
    end
    checks++; if (got != 50) begin errors++; $display("FAIL b2b_count: got %0d want 50", got); end
    checks++; if (first != 3) begin errors++; $display("FAIL b2b_fill: got cycle %0d want 3", first); end
    checks++; if (last - first != 49) begin errors++;
      $display("FAIL b2b_gapless: got span %0d want 49", last - first); end
  endtask

  task automatic test_backpressure();
    logic [31:0] set [6];
    logic [9:0]  e [6];
    int idx = 0, recv = 0;
    for (int k = 0; k < 6; k++) begin
      set[k] = {8'(k*37 + 5), 8'(k*11 + 200), 8'(k*3 + 17), 8'(255 - k*29)};
      e[k] = 10'(set[k][7:0]) + 10'(set[k][15:8]) + 10'(set[k][23:16]) + 10'(set[k][31:24]);
    end
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      ordy0 = (cyc >= 6);
      iv0 = (idx < 6);
      ops0 = (idx < 6) ? set[idx] : 32'h0;
      #1;
      if (cyc >= 3 && cyc < 6) begin
        checks++; if (ir0 !== 1'b0) begin errors++;
          $display("FAIL bp_in_ready cycle %0d: got %b want 0", cyc, ir0); end
        checks++; if (ov0 !== 1'b1 || sum0 !== e[0]) begin errors++;
          $display("FAIL bp_hold cycle %0d: got valid=%b sum=%h want valid=1 sum=%h", cyc, ov0, sum0, e[0]); end
      end
      if (cyc == 6) begin
        checks++; if (idx != 3) begin errors++; $display("FAIL bp_capacity: got %0d sets want 3", idx); end
      end
      if (ov0 && ordy0) begin
        checks++; if (sum0 !== e[recv]) begin errors++;
          $display("FAIL bp_order[%0d]: got %h want %h", recv, sum0, e[recv]); end
        recv++;
      end
      if (iv0 && ir0) idx++;
      @(negedge clk);
    end
    checks++; if (recv != 6 || idx != 6) begin errors++;
      $display("FAIL bp_count: got recv=%0d sent=%0d want 6/6", recv, idx); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_duplicate: got out_valid=%b want 0", ov0); end
    iv0 = 1'b0; ordy0 = 1'b1;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    ordy0 = 1'b1;
    ops0 = 32'h01020304; iv0 = 1'b1;
    @(negedge clk);
    ops0 = 32'h10203040;
    @(negedge clk);
    iv0 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", ov0); end
    checks++; if (sum0 !== 10'h000) begin errors++; $display("FAIL midreset_sum: got %h want 000", sum0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov0 !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles want 0", stale); end
    ops0 = {4{8'h11}}; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (ov0 !== (c == 3)) begin errors++;
        $display("FAIL midreset_latency cycle %0d: got out_valid=%b want %b", c, ov0, (c == 3)); end
      if (c < 3) @(negedge clk);
    end
    checks++; if (sum0 !== 10'h044) begin errors++; $display("FAIL midreset_sum_after: got %h want 044", sum0); end
    @(negedge clk);
  endtask

  initial begin
    ops0 = '0; iv0 = 1'b0; ordy0 = 1'b1;
    ops1 = '0; iv1 = 1'b0; ordy1 = 1'b1;
    ops2 = '0; iv2 = 1'b0; ordy2 = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_nine_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/csa_tree_adder.md
# csa_tree_adder

Parametrised, pipelined multi-operand adder. It reduces NUM_OPS operands of WIDTH bits to a single sum using rows of 3:2 carry-save compressors built from full-adder cells, followed by a final carry-propagate add. There is a pipeline register after every compressor level and after the final add. It is the reduction core for the Wallace-tree multiplier datapath and for any multi-operand accumulation. A valid/ready handshake with full backpressure lets it sit between streaming stages.

## Interface
Parameters:
- WIDTH, 8: operand width in bits (2..32).
- NUM_OPS, 4: number of operands (3..9).
- SIGNED, 0: 1 = operands are two's complement and are sign-extended; 0 = zero-extended.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. Single clock, asynchronous active-low reset.
- in_ops  in  NUM_OPS*WIDTH  operand i at bits [i*WIDTH +: WIDTH].
- in_valid  in  1  in_ops is valid this cycle.
- in_ready  out  1  the block accepts in_ops this cycle.
- out_sum  out  OUT_W  sum, where OUT_W = WIDTH + clog2(NUM_OPS).
- out_valid  out  1  out_sum is valid.
- out_ready  in  1  downstream accepts out_sum.

## Operation
- Each operand is extended to OUT_W bits: sign-extended if SIGNED=1, zero-extended otherwise. All arithmetic is modulo 2^OUT_W.
- Reduction levels L (3:2 scheme):
  - NUM_OPS=3 → L=1
  - NUM_OPS=4 → L=2
  - NUM_OPS=5..6 → L=3
  - NUM_OPS=7..9 → L=4
- Each level groups the live vectors in threes, from index 0 upward. Each group feeds one compressor row, which produces a sum vector and a carry vector; the carry vector is shifted left by 1 and the MSB carry is dropped. Leftover vectors (1 or 2) pass through unchanged. All outputs of the level are registered.
- After level L exactly two vectors remain. A carry-propagate add of the two is registered into out_sum.
- Each pipeline stage holds a valid bit alongside its data.
- stall = out_valid & ~out_ready.
  - When stall=1, every stage register, including the valid bits, holds its value.
  - in_ready = ~stall, combinational.
  - A transfer occurs when in_valid & in_ready.
- When not stalled, each valid bit advances by one stage per cycle. A bubble (in_valid=0) enters as valid=0 and its data is don't-care.
- While out_valid=1, out_sum is stable until the cycle the handshake completes.
- Reset:
  - All valid bits are 0, out_valid=0, out_sum=0. in_ready=1 as soon as reset is released.
  - Reset asserted mid-operation discards every in-flight operand set. Nothing partial is emitted after release.

## Timing
- Latency is L+1 cycles from the accepting edge to out_valid=1 (NUM_OPS=4: 3 cycles).
- Throughput is one operand set per cycle when out_ready is held at 1.
- in_ready drops in the same cycle that out_valid=1 and out_ready=0, with no extra cycle of delay. Capacity is therefore exactly L+1 sets and there is no skid buffer.
- When in_valid=1 and stall=1 in the same cycle, the operands are not consumed. The source must hold in_ops.
- out_ready may toggle every cycle. Each out_valid&out_ready cycle retires exactly one result, in input order.

## Structure
- Shared package csa_pkg:
  - function csa_levels(n), implementing the table above.
  - function csa_out_w(width, n).
  - localparams MAX_OPS=9 and MAX_LEVELS=4.
- Sub-module csa_row: a WIDTH-parameterised row of full-adder cells mapping three OUT_W vectors to a sum vector and a shifted-carry vector. Purely combinational.
- The top level generates L levels of csa_row instances plus the register bank, the final carry-propagate adder, and the valid pipeline with stall logic.

## Test plan
- WIDTH=8, NUM_OPS=4, SIGNED=0:
  - Operands 255,255,255,255, out_ready=1 → out_sum=1020 (10'h3FC), out_valid exactly 3 cycles after acceptance.
  - Operands 0,0,0,0 → 0.
- SIGNED=1, NUM_OPS=4: operands 8'h80 ×4 → out_sum=10'h200 (−512). Operands 8'h7F,8'h80,8'h01,8'hFF → 10'h3FF (−1).
- Back-to-back streaming: 50 random sets with out_ready=1 → 50 results in order, one per cycle after 3-cycle fill, each matching a reference sum.
- Backpressure: hold out_ready=0 for 6 cycles with in_valid=1 → in_ready=0 after 3 sets fill the pipe. out_sum is stable. Release → all sets emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 2 sets in flight → out_valid=0 and out_sum=0 immediately. After release, no stale result appears and the next set completes with 3-cycle latency.
- NUM_OPS=9, WIDTH=4: operands 15 ×9 → out_sum=135 (8'h87), latency 5 cycles.
